fsic_io_serdes_rx_ctrl: RTL and testbench

Link-training controller for the FSIC IO SERDES receive lane, running in the coreclk domain beside the SERDES receiver. It sequences the receiver enable (rxen) and waits for the first valid nibble. It then finds the nibble bit alignment by matching a fixed training pattern under a rotating bit-slip. Aligned nibbles are forwarded to the core with link_up asserted only after lock.

---
 rtl/fsic_io_serdes_rx_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fsic_io_serdes_rx_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fsic_io_serdes_rx_ctrl.sv
// Link-training controller for the FSIC IO SERDES receive lane (coreclk domain).
// Define FSIC_RX_CTRL_BITSLIP_EN to enable the rotating bit-slip alignment search.
module fsic_io_serdes_rx_ctrl #(
    parameter int                    pCLK_RATIO     = 4,
    parameter logic [pCLK_RATIO-1:0] pTRAIN_PATTERN = 4'b0011,
    parameter int                    pLOCK_CNT      = 8,
    parameter int                    pSLIP_WIN      = 4,
    parameter int                    pTIMEOUT       = 255,
    parameter int                    pMAX_SLIP      = 8
) (
    input  logic                          coreclk,
    input  logic                          axis_rst,
    input  logic                          ctrl_en,
    input  logic                          retrain,
    input  logic [pCLK_RATIO-1:0]         rxdata_in,
    input  logic                          rxdata_in_valid,
    output logic                          rxen,
    output logic [pCLK_RATIO-1:0]         rxdata_out,
    output logic                          rxdata_out_valid,
    output logic                          link_up,
    output logic [$clog2(pCLK_RATIO)-1:0] slip,
    output logic                          link_err,
    output logic [2:0]                    state
);

    localparam int SLIP_W  = $clog2(pCLK_RATIO);
    localparam int WAIT_W  = $clog2(pTIMEOUT + 1);
    localparam int MATCH_W = $clog2(pLOCK_CNT + 1);
`ifdef FSIC_RX_CTRL_BITSLIP_EN
    localparam int MISS_LIM = pSLIP_WIN;
`else
    localparam int MISS_LIM = pSLIP_WIN * pMAX_SLIP;
`endif
    localparam int MISS_W  = $clog2(MISS_LIM + 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EN         = 3'd1,
        ST_WAIT_VALID = 3'd2,
        ST_TRAIN      = 3'd3,
        ST_SLIP       = 3'd4,
        ST_LINK_UP    = 3'd5,
        ST_ERR        = 3'd6
    } state_t;

    // aligned[i] = d[(i + s) mod N], taken from a doubled word shifted right by s
    function automatic logic [pCLK_RATIO-1:0] f_align(input logic [pCLK_RATIO-1:0] d,
                                                     input logic [SLIP_W-1:0]     s);
        logic [2*pCLK_RATIO-1:0] t;
        t = {d, d} >> s;
        return t[pCLK_RATIO-1:0];
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [MATCH_W-1:0]    r_match_cnt;
    logic [MISS_W-1:0]     r_miss_cnt;
    logic [WAIT_W-1:0]     w_wait_inc;
    logic [MATCH_W-1:0]    w_match_inc;
    logic [MISS_W-1:0]     w_miss_inc;
    logic [SLIP_W-1:0]     w_slip;
    logic [pCLK_RATIO-1:0] w_aligned;
    logic                  w_match;

    logic                  r_rxen;
    logic [pCLK_RATIO-1:0] r_rxdata_out;
    logic                  r_link_up;
    logic                  r_link_err;

`ifdef FSIC_RX_CTRL_BITSLIP_EN
    localparam int SCNT_W = $clog2(pMAX_SLIP + 1);
    logic [SLIP_W-1:0] r_slip;
    logic [SCNT_W-1:0] r_slip_cnt;
    logic [SCNT_W-1:0] w_slip_cnt_inc;

    assign w_slip         = r_slip;
    assign w_slip_cnt_inc = r_slip_cnt + SCNT_W'(1);
`else
    assign w_slip = '0;
`endif

    assign w_aligned   = f_align(rxdata_in, w_slip);
    assign w_match     = (w_aligned == pTRAIN_PATTERN);
    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);
    assign w_match_inc = r_match_cnt + MATCH_W'(1);
    assign w_miss_inc  = r_miss_cnt + MISS_W'(1);

    // ctrl_en low overrides every transition
    always_comb begin
        w_next = r_state;
        if (!ctrl_en) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       w_next = ST_EN;
                ST_EN:         w_next = ST_WAIT_VALID;
                ST_WAIT_VALID: begin
                    if (rxdata_in_valid)
                        w_next = ST_TRAIN;
                    else if (r_wait_cnt == WAIT_W'(pTIMEOUT - 1))
                        w_next = ST_ERR;
                end
                ST_TRAIN: begin
                    if (!rxdata_in_valid) begin
                        w_next = ST_WAIT_VALID;
                    end else if (w_match) begin
                        if (w_match_inc == MATCH_W'(pLOCK_CNT))
                            w_next = ST_LINK_UP;
                    end else if (w_miss_inc == MISS_W'(MISS_LIM)) begin
`ifdef FSIC_RX_CTRL_BITSLIP_EN
                        w_next = ST_SLIP;
`else
                        w_next = ST_ERR;
`endif
                    end
                end
`ifdef FSIC_RX_CTRL_BITSLIP_EN
                ST_SLIP: begin
                    if (w_slip_cnt_inc == SCNT_W'(pMAX_SLIP))
                        w_next = ST_ERR;
                    else
                        w_next = ST_TRAIN;
                end
`endif
                ST_LINK_UP: begin
                    if (retrain)
                        w_next = ST_EN;
                    else if (!rxdata_in_valid)
                        w_next = ST_WAIT_VALID;
                end
                ST_ERR:  w_next = ST_ERR;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State, counters and next-state-decoded registered outputs
    always_ff @(posedge coreclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_rxen       <= 1'b0;
            r_rxdata_out <= '0;
            r_link_up    <= 1'b0;
            r_link_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == ST_WAIT_VALID && w_next == ST_WAIT_VALID)
                r_wait_cnt <= w_wait_inc;
            else
                r_wait_cnt <= '0;

            if (r_state == ST_TRAIN && w_next == ST_TRAIN) begin
                r_match_cnt <= w_match ? w_match_inc : '0;
                r_miss_cnt  <= w_match ? '0 : w_miss_inc;
            end else begin
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
            end

            r_rxen       <= (w_next == ST_EN) || (w_next == ST_WAIT_VALID) ||
                            (w_next == ST_TRAIN) || (w_next == ST_SLIP) ||
                            (w_next == ST_LINK_UP);
            r_rxdata_out <= w_aligned;
            r_link_up    <= (w_next == ST_LINK_UP);
            r_link_err   <= (w_next == ST_ERR);
        end
    end

`ifdef FSIC_RX_CTRL_BITSLIP_EN
    // Slip position and slip-attempt count; slip is frozen outside SLIP
    always_ff @(posedge coreclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_slip     <= '0;
            r_slip_cnt <= '0;
        end else begin
            if (w_next == ST_IDLE)
                r_slip <= '0;
            else if (r_state == ST_SLIP)
                r_slip <= (r_slip == SLIP_W'(pCLK_RATIO - 1)) ? '0 : r_slip + SLIP_W'(1);
            else if (r_state == ST_LINK_UP && w_next == ST_EN)
                r_slip <= '0;

            if (r_state == ST_SLIP)
                r_slip_cnt <= w_slip_cnt_inc;
            else if (r_state == ST_TRAIN && (w_next == ST_TRAIN || w_next == ST_SLIP))
                r_slip_cnt <= r_slip_cnt;
            else
                r_slip_cnt <= '0;
        end
    end
`endif

    assign rxen             = r_rxen;
    assign rxdata_out       = r_rxdata_out;
    assign rxdata_out_valid = r_link_up;
    assign link_up          = r_link_up;
    assign link_err         = r_link_err;
    assign slip             = w_slip;
    assign state            = r_state;

endmodule

// File: tb/tb_fsic_io_serdes_rx_ctrl.sv
// Directed bench for fsic_io_serdes_rx_ctrl: vector table plus multi-cycle sequences.
module tb_fsic_io_serdes_rx_ctrl;

    logic       coreclk = 1'b0;
    logic       axis_rst;
    logic       ctrl_en;
    logic       retrain;
    logic [3:0] rxdata_in;
    logic       rxdata_in_valid;
    logic       rxen;
    logic [3:0] rxdata_out;
    logic       rxdata_out_valid;
    logic       link_up;
    logic [1:0] slip;
    logic       link_err;
    logic [2:0] state;

    int n_checks = 0;
    int n_err    = 0;

    always #5 coreclk = ~coreclk;

    fsic_io_serdes_rx_ctrl dut (
        .coreclk          (coreclk),
        .axis_rst         (axis_rst),
        .ctrl_en          (ctrl_en),
        .retrain          (retrain),
        .rxdata_in        (rxdata_in),
        .rxdata_in_valid  (rxdata_in_valid),
        .rxen             (rxen),
        .rxdata_out       (rxdata_out),
        .rxdata_out_valid (rxdata_out_valid),
        .link_up          (link_up),
        .slip             (slip),
        .link_err         (link_err),
        .state            (state)
    );

    // {state, rxen, link_up, rxdata_out_valid, link_err, slip, rxdata_out}
    logic [13:0] obs;
    assign obs = {state, rxen, link_up, rxdata_out_valid, link_err, slip, rxdata_out};

    typedef struct {
        logic       ce;
        logic       rt;
        logic       vl;
        logic [3:0] din;
        logic [2:0] st;
        logic       rxen;
        logic       lu;
        logic       err;
        logic [3:0] dout;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic ce, input logic rt, input logic vl,
                                input logic [3:0] din, input logic [2:0] st,
                                input logic rx, input logic lu, input logic err,
                                input logic [3:0] dout);
        vec_t v;
        v.ce = ce; v.rt = rt; v.vl = vl; v.din = din; v.st = st;
        v.rxen = rx; v.lu = lu; v.err = err; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge coreclk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input logic ce, input logic rt, input logic vl, input logic [3:0] d);
        ctrl_en         = ce;
        retrain         = rt;
        rxdata_in_valid = vl;
        rxdata_in       = d;
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        axis_rst = 1'b1;
        steps(2);
        check("reset_values", 32'(obs), 32'h0);
        axis_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pool [3];
        pool[0] = 4'b0000;
        pool[1] = 4'b1111;
        pool[2] = 4'b0101;

        // Lock, run, retrain, re-lock, valid loss, ignored retrain, disable
        tbl[0]  = mk(1, 0, 1, 4'b0000, 3'd1, 1, 0, 0, 4'b0000);
        tbl[1]  = mk(1, 0, 1, 4'b0000, 3'd2, 1, 0, 0, 4'b0000);
        tbl[2]  = mk(1, 0, 1, 4'b0000, 3'd3, 1, 0, 0, 4'b0000);
        for (int i = 3; i <= 9; i++)
            tbl[i] = mk(1, 0, 1, 4'b0011, 3'd3, 1, 0, 0, 4'b0011);
        tbl[10] = mk(1, 0, 1, 4'b0011, 3'd5, 1, 1, 0, 4'b0011);
        tbl[11] = mk(1, 0, 1, 4'b0110, 3'd5, 1, 1, 0, 4'b0110);
        tbl[12] = mk(1, 1, 1, 4'b0011, 3'd1, 1, 0, 0, 4'b0011);
        tbl[13] = mk(1, 0, 1, 4'b0011, 3'd2, 1, 0, 0, 4'b0011);
        tbl[14] = mk(1, 0, 0, 4'b0011, 3'd2, 1, 0, 0, 4'b0011);
        tbl[15] = mk(1, 0, 1, 4'b0011, 3'd3, 1, 0, 0, 4'b0011);
        for (int i = 16; i <= 22; i++)
            tbl[i] = mk(1, 0, 1, 4'b0011, 3'd3, 1, 0, 0, 4'b0011);
        tbl[23] = mk(1, 0, 1, 4'b0011, 3'd5, 1, 1, 0, 4'b0011);
        tbl[24] = mk(1, 0, 0, 4'b1010, 3'd2, 1, 0, 0, 4'b1010);
        tbl[25] = mk(1, 1, 0, 4'b1010, 3'd2, 1, 0, 0, 4'b1010);
        tbl[26] = mk(0, 0, 0, 4'b0000, 3'd0, 0, 0, 0, 4'b0000);

        axis_rst = 1'b1;
        apply_reset();

        for (int i = 0; i < 27; i++) begin
            logic [13:0] exp_obs;
            drive(tbl[i].ce, tbl[i].rt, tbl[i].vl, tbl[i].din);
            tick();
            exp_obs = {tbl[i].st, tbl[i].rxen, tbl[i].lu, tbl[i].lu, tbl[i].err,
                       2'b00, tbl[i].dout};
            check($sformatf("vec%0d", i), 32'(obs), 32'(exp_obs));
        end

        // WAIT_VALID timeout: 255 cycles without valid, then ERR; ctrl_en low exits
        apply_reset();
        drive(1, 0, 0, 4'h0);
        steps(2);
        check("timeout_enter_wait", 32'(state), 32'd2);
        steps(254);
        check("timeout_still_wait", 32'(state), 32'd2);
        steps(1);
        check("timeout_err", 32'({state, link_err, rxen}), 32'({3'd6, 1'b1, 1'b0}));
        drive(0, 0, 0, 4'h0);
        steps(1);
        check("err_to_idle", 32'({state, link_err, rxen}), 32'({3'd0, 1'b0, 1'b0}));

`ifdef FSIC_RX_CTRL_BITSLIP_EN
        // 1001 aligns at slip=3 after three slip passes of 5 cycles each
        apply_reset();
        drive(1, 0, 1, 4'b1001);
        steps(7);
        check("slip1_enter", 32'({state, slip}), 32'({3'd4, 2'd0}));
        steps(1);
        check("slip1_exit", 32'({state, slip}), 32'({3'd3, 2'd1}));
        steps(10);
        check("slip3_train", 32'({state, slip}), 32'({3'd3, 2'd3}));
        steps(7);
        check("slip3_no_lock_yet", 32'({state, link_up}), 32'({3'd3, 1'b0}));
        steps(1);
        check("slip3_lock", 32'({state, link_up, rxdata_out_valid}), 32'({3'd5, 1'b1, 1'b1}));
        steps(1);
        check("slip3_dout", 32'({rxdata_out, slip}), 32'({4'b0011, 2'd3}));

        // Non-pattern data: eight slips, slip wraps 3->0, then ERR
        apply_reset();
        drive(1, 0, 1, pool[0]);
        for (int i = 0; i < 42; i++) begin
            rxdata_in = pool[i % 3];
            tick();
        end
        check("slip8_enter", 32'({state, slip}), 32'({3'd4, 2'd3}));
        steps(1);
        check("slip8_err", 32'({state, slip, link_err, rxen}), 32'({3'd6, 2'd0, 1'b1, 1'b0}));
`else
        // Without bit-slip, 32 consecutive misses lead to ERR with slip fixed at 0
        apply_reset();
        drive(1, 0, 1, 4'b1001);
        steps(34);
        check("noslip_train", 32'({state, slip}), 32'({3'd3, 2'd0}));
        steps(1);
        check("noslip_err", 32'({state, slip, link_err, rxen}), 32'({3'd6, 2'd0, 1'b1, 1'b0}));
`endif

        // Asynchronous reset mid-TRAIN (match_cnt=5), then clean retrain
        apply_reset();
        drive(1, 0, 1, 4'b0011);
        steps(8);
        check("pre_rst_train", 32'(state), 32'd3);
        #2 axis_rst = 1'b1;
        #1 check("async_rst", 32'(obs), 32'h0);
        #1 axis_rst = 1'b0;
        steps(10);
        check("post_rst_train", 32'({state, link_up}), 32'({3'd3, 1'b0}));
        steps(1);
        check("post_rst_lock", 32'({state, link_up, rxdata_out}), 32'({3'd5, 1'b1, 4'b0011}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
